// File: rtl/mig_seq_pkg.sv
// Shared types and source-select encoding for the MIG node sequencer.
package mig_seq_pkg;

  localparam int unsigned MIG_SEL_W  = 5;
  localparam int unsigned SRC_CONST0 = 0;
  localparam int unsigned SRC_X_BASE = 1;
  localparam int unsigned SRC_W_BASE = 8;

  typedef struct packed {
    logic                 inv;
    logic [MIG_SEL_W-1:0] sel;
  } mig_op_t;

  typedef struct packed {
    mig_op_t opC;
    mig_op_t opB;
    mig_op_t opA;
  } mig_node_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } mig_state_t;

endpackage

// File: rtl/mig_node_sequencer_maj3_cell.sv
// Combinational 3-input majority with per-input inversion.
module maj3_cell (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [2:0] inv_i,
  output logic       y_o
);

  logic a, b, c;

  always_comb begin
    a   = a_i ^ inv_i[0];
    b   = b_i ^ inv_i[1];
    c   = c_i ^ inv_i[2];
    y_o = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/mig_node_sequencer.sv
// Serial MIG evaluator: one table node per cycle through a single shared majority cell.
module mig_node_sequencer
  import mig_seq_pkg::*;
#(
  parameter int unsigned NUM_NODES = 16,
  parameter int unsigned ADDR_W    = $clog2(NUM_NODES),
  parameter int unsigned SEL_W     = MIG_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [3*(SEL_W+1)-1:0] cfg_data,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic [6:0]           x,
  input  logic [ADDR_W:0]      len,
  input  logic                 out_inv,
  output logic                 busy,
  output logic                 done,
  output logic                 out,
  output logic                 err
);

  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  mig_state_t           state_q, state_d;
  mig_node_t            tbl_q [NUM_NODES];
  logic [NUM_NODES-1:0] wres_q;
  logic [ADDR_W-1:0]    cnt_q;
  logic [ADDR_W:0]      len_q;
  logic [6:0]           x_q;
  logic                 inv_q;
  logic                 run_err_q;
  logic                 out_q, err_q, cfg_err_q;

  mig_node_t  cur_node;
  mig_op_t    ops [3];
  logic [1:0] op_res [3];
  logic [2:0] op_val, op_inv;
  logic       node_err, maj_y, len_ok, last_node;

  // Returns {legal, source value}; an operand may only reference nodes already evaluated this run.
  function automatic logic [1:0] resolve_op(input mig_op_t op, input logic [ADDR_W-1:0] cur,
                                            input logic [6:0] xv, input logic [NUM_NODES-1:0] wv);
    int unsigned s, k;
    s = 32'(op.sel);
    if (s < SRC_X_BASE) return 2'b10;
    if (s < SRC_W_BASE) return {1'b1, xv[3'(s - SRC_X_BASE)]};
    k = s - SRC_W_BASE;
    if (k < 32'(cur)) return {1'b1, wv[ADDR_W'(k)]};
    return 2'b00;
  endfunction

  always_comb begin
    cur_node = tbl_q[cnt_q];
    ops[0]   = cur_node.opA;
    ops[1]   = cur_node.opB;
    ops[2]   = cur_node.opC;
    node_err = 1'b0;
    op_val   = '0;
    op_inv   = '0;
    for (int unsigned j = 0; j < 3; j++) begin
      op_res[j] = resolve_op(ops[j], cnt_q, x_q, wres_q);
      op_val[j] = op_res[j][0];
      // An illegal operand is forced to a plain 0, so its inversion bit is dropped too.
      op_inv[j] = ops[j].inv & op_res[j][1];
      node_err  = node_err | ~op_res[j][1];
    end
  end

  maj3_cell u_maj (
    .a_i   (op_val[0]),
    .b_i   (op_val[1]),
    .c_i   (op_val[2]),
    .inv_i (op_inv),
    .y_o   (maj_y)
  );

  always_comb begin
    len_ok    = (len != '0) && (32'(len) <= NUM_NODES);
    last_node = ({1'b0, cnt_q} == (len_q - LEN_ONE));
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = len_ok ? EVAL : DONE;
      EVAL:    if (last_node) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int unsigned i = 0; i < NUM_NODES; i++) tbl_q[i] <= '0;
      wres_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      x_q       <= '0;
      inv_q     <= 1'b0;
      run_err_q <= 1'b0;
      out_q     <= 1'b0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_we && (state_q != IDLE);
      if (cfg_we && (state_q == IDLE)) tbl_q[cfg_addr] <= mig_node_t'(cfg_data);
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q       <= x;
            len_q     <= len;
            inv_q     <= out_inv;
            cnt_q     <= '0;
            run_err_q <= 1'b0;
            if (!len_ok) begin
              out_q <= 1'b0;
              err_q <= 1'b1;
            end
          end
        end
        EVAL: begin
          wres_q[cnt_q] <= maj_y;
          run_err_q     <= run_err_q | node_err;
          cnt_q         <= cnt_q + CNT_ONE;
          if (last_node) begin
            out_q <= maj_y ^ inv_q;
            err_q <= run_err_q | node_err;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q == EVAL);
    done    = (state_q == DONE);
    out     = out_q;
    err     = err_q;
    cfg_err = cfg_err_q;
  end

endmodule

// File: tb/tb_mig_node_sequencer.sv
// Self-checking bench: directed vector table, hand sequences, and randomized runs against a counting model.
module tb_mig_node_sequencer;
  import mig_seq_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, cfg_we, cfg_err, start, out_inv, busy, done, out, err;
  logic [3:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic [6:0]  x;
  logic [4:0]  len;

  int n_pass = 0;
  int n_total = 0;
  logic [17:0] m_tbl [N];

  typedef struct {
    logic [6:0] xv;
    int         lenv;
    logic       inv;
    logic       eo;
    logic       ee;
  } vec_t;

  mig_node_sequencer #(.NUM_NODES(16), .SEL_W(5)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .start(start), .x(x), .len(len), .out_inv(out_inv),
    .busy(busy), .done(done), .out(out), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic logic [5:0] op(input logic inv, input int sel);
    return {inv, sel[4:0]};
  endfunction

  function automatic logic [17:0] nd(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {c, b, a};
  endfunction

  // Reference: each operand resolved from its select, node value = at least two of three ones.
  function automatic void model(input logic [6:0] xv, input int lenv, input logic inv,
                                output logic o, output logic e);
    logic       w [N];
    logic [5:0] opv;
    int         s, ones;
    logic       v;
    o = 1'b0;
    e = 1'b0;
    if (lenv < 1 || lenv > N) begin
      e = 1'b1;
      return;
    end
    for (int i = 0; i < lenv; i++) begin
      ones = 0;
      for (int j = 0; j < 3; j++) begin
        opv = m_tbl[i][6*j +: 6];
        s = int'(opv[4:0]);
        if (s == 0) v = opv[5];
        else if (s < 8) v = xv[s-1] ^ opv[5];
        else if (s - 8 < i) v = w[s-8] ^ opv[5];
        else begin
          v = 1'b0;
          e = 1'b1;
        end
        if (v) ones++;
      end
      w[i] = (ones >= 2);
    end
    o = w[lenv-1] ^ inv;
  endfunction

  task automatic write_node(input int a, input logic [17:0] d);
    cfg_we = 1'b1;
    cfg_addr = a[3:0];
    cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_tbl[a] = d;
  endtask

  task automatic run(input string name, input logic [6:0] xv, input int lenv, input logic inv,
                     input logic eo, input logic ee);
    int cyc, exp_lat;
    exp_lat = (lenv >= 1 && lenv <= N) ? lenv + 1 : 1;
    x = xv;
    len = 5'(lenv);
    out_inv = inv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 7'($urandom);
    out_inv = 1'($urandom);
    cyc = 1;
    if (exp_lat > 1) check({name, " busy"}, int'(busy), 1);
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, cyc, exp_lat);
    check({name, " out"}, int'(out), int'(eo));
    check({name, " err"}, int'(err), int'(ee));
    @(posedge clk); #1;
    check({name, " hold"}, int'({done, busy, out, err}), int'({2'b00, eo, ee}));
  endtask

  vec_t vt [9];

  initial begin
    int   cyc, seen;
    logic eo, ee;

    vt[0] = '{7'b0111011, 4, 1'b0, 1'b1, 1'b0};
    vt[1] = '{7'b0000000, 4, 1'b0, 1'b0, 1'b0};
    vt[2] = '{7'b0000000, 4, 1'b1, 1'b1, 1'b0};
    vt[3] = '{7'b0000001, 4, 1'b0, 1'b0, 1'b0};
    vt[4] = '{7'b0100010, 4, 1'b0, 1'b0, 1'b0};
    vt[5] = '{7'b0000011, 4, 1'b0, 1'b1, 1'b0};
    vt[6] = '{7'b0111011, 2, 1'b0, 1'b1, 1'b0};
    vt[7] = '{7'b0000011, 2, 1'b0, 1'b0, 1'b0};
    vt[8] = '{7'b0000011, 3, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < N; i++) m_tbl[i] = '0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; x = '0; len = '0; out_inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", int'({busy, done, out, err, cfg_err}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    write_node(0, nd(op(0, 1), op(0, 2), op(0, 3)));
    run("single", 7'b0000011, 1, 1'b0, 1'b1, 1'b0);
    write_node(0, nd(op(1, 1), op(0, 0), op(0, 2)));
    run("inversion", 7'b0000010, 1, 1'b1, 1'b0, 1'b0);

    write_node(0, nd(op(0, 9), op(0, 1), op(0, 2)));
    run("fwd ref a", 7'b0000011, 1, 1'b0, 1'b1, 1'b1);
    run("fwd ref b", 7'b0000001, 1, 1'b0, 1'b0, 1'b1);
    write_node(0, nd(op(1, 8), op(0, 1), op(0, 0)));
    run("self ref inv", 7'b0000001, 1, 1'b0, 1'b0, 1'b1);
    run("len zero", 7'h7f, 0, 1'b1, 1'b0, 1'b1);
    run("len over", 7'h7f, 17, 1'b1, 1'b0, 1'b1);

    write_node(0, nd(op(0, 1), op(0, 2), op(0, 5)));
    write_node(1, nd(op(0, 2), op(0, 4), op(0, 5)));
    write_node(2, nd(op(0, 6), op(0, 2), op(0, 9)));
    write_node(3, nd(op(0, 1), op(0, 8), op(0, 10)));
    for (int i = 0; i < 9; i++)
      run($sformatf("chain vec%0d", i), vt[i].xv, vt[i].lenv, vt[i].inv, vt[i].eo, vt[i].ee);

    // Write and start attempted while busy, then again in the done cycle.
    x = 7'b0111011; len = 5'd4; out_inv = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    x = 7'b0000000; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    check("busy write cfg_err", int'(cfg_err), 1);
    cyc = 2;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy write latency", cyc, 5);
    check("busy write out", int'(out), 1);
    cfg_we = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    check("done write cfg_err", int'(cfg_err), 1);
    check("done start ignored", int'({busy, done}), 0);
    @(posedge clk); #1;
    check("cfg_err pulse end", int'(cfg_err), 0);
    run("table intact", 7'b0111011, 4, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a run.
    x = 7'b0111011; len = 5'd4; out_inv = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-run reset", int'({busy, done, out, err, cfg_err}), 0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no done after reset", seen, 0);
    for (int i = 0; i < N; i++) m_tbl[i] = '0;
    run("cleared table", 7'h7f, 1, 1'b0, 1'b0, 1'b0);

    // Write and start in the same idle cycle: the run sees the new entry.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = nd(op(1, 0), op(1, 0), op(0, 0));
    m_tbl[0] = cfg_data;
    run("write+start", 7'h00, 1, 1'b0, 1'b1, 1'b0);
    cfg_we = 1'b0;

    for (int r = 0; r < 60; r++) begin
      logic [6:0] xv;
      int         lv, nw, sa, sb, sc;
      logic       iv;
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) begin
        sa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23);
        sb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23);
        sc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23);
        write_node($urandom_range(0, N-1),
                   nd(op(1'($urandom), sa), op(1'($urandom), sb), op(1'($urandom), sc)));
      end
      xv = 7'($urandom);
      lv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, N);
      iv = 1'($urandom);
      model(xv, lv, iv, eo, ee);
      run($sformatf("rand%0d", r), xv, lv, iv, eo, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
